// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between NUM_REQ requesters, one op in flight.
// Latency: accept at edge T, response valid from T+2 (extended by ALU busy cycles).
// Backpressure: result held in RESP until owner's rsp_ready_i; grants only in IDLE or the RESP handshake cycle.
package alu_arbiter_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        alu_nop  = 4'd0,
        alu_add  = 4'd1,
        alu_sub  = 4'd2,
        alu_and  = 4'd3,
        alu_or   = 4'd4,
        alu_xor  = 4'd5,
        alu_eq   = 4'd6,
        alu_lt_s = 4'd7,
        alu_ge_s = 4'd8,
        alu_ge_u = 4'd9
    } aluop_t;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  word_t [NUM_REQ-1:0]      req_data1_i,
    input  word_t [NUM_REQ-1:0]      req_data2_i,
    input  aluop_t [NUM_REQ-1:0]     req_op_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output word_t                    rsp_result_o,
    output word_t                    alu_data1_o,
    output word_t                    alu_data2_o,
    output aluop_t                   alu_op_o,
    input  word_t                    alu_result_i,
    input  logic                     alu_busy_i,
    output logic                     busy_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  owner_q;
    word_t             data1_q, data2_q, result_q;
    aluop_t            op_q;

    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  ptr_next;
    logic              rsp_hs;
    logic              grant_open;
    logic              accept;

    // Scan from rr_ptr upward with wrap; the first asserted valid wins.
    always_comb begin
        logic [IDX_W:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!win_vld && req_valid_i[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign rsp_hs     = (state_q == RESP) && rsp_ready_i[owner_q];
    // Window also closed while reset is asserted so ready reads 0 during reset.
    assign grant_open = rst_n && ((state_q == IDLE) || rsp_hs);
    assign accept     = grant_open && win_vld;
    assign ptr_next   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = accept && (win_idx == IDX_W'(i));
            rsp_valid_o[i] = (state_q == RESP) && (owner_q == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: if (!alu_busy_i) state_d = RESP;
            RESP: if (rsp_hs) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            op_q     <= alu_nop;
            result_q <= '0;
        end else begin
            if (accept) begin
                data1_q  <= req_data1_i[win_idx];
                data2_q  <= req_data2_i[win_idx];
                op_q     <= req_op_i[win_idx];
                owner_q  <= win_idx;
                rr_ptr_q <= ptr_next;
            end
            if ((state_q == EXEC) && !alu_busy_i) begin
                result_q <= alu_result_i;
            end
        end
    end

    // ALU sees only the registered operands and only during EXEC.
    assign alu_data1_o  = (state_q == EXEC) ? data1_q : '0;
    assign alu_data2_o  = (state_q == EXEC) ? data2_q : '0;
    assign alu_op_o     = (state_q == EXEC) ? op_q : alu_nop;
    assign rsp_result_o = (state_q == RESP) ? result_q : '0;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle ALU datapath between NUM_REQ requesters, e.g. the EX stage and the branch-compare unit.
- Each requester uses valid/ready on both the request and the response side.
- Grants use a round-robin policy; one operation is outstanding at a time.
- Operands are registered before the ALU and the result is registered after it, so the ALU sits in a clean single-cycle slot.
- Sits between the issue logic and the alu instance; it drives the ALU's data1/data2/op inputs and consumes its result and busy outputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IDX_W, $clog2(NUM_REQ) (min 1), owner index width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid_i  input  NUM_REQ  per-requester request valid
- req_ready_o  output  NUM_REQ  per-requester accept, one-hot or zero
- req_data1_i  input  NUM_REQ x word  operand 1 per requester
- req_data2_i  input  NUM_REQ x word  operand 2 per requester
- req_op_i  input  NUM_REQ x aluop  operation per requester
- rsp_valid_o  output  NUM_REQ  result valid, one-hot to owner
- rsp_ready_i  input  NUM_REQ  per-requester result accept
- rsp_result_o  output  word  result, shared, qualified by rsp_valid_o
- alu_data1_o  output  word  to ALU operand 1
- alu_data2_o  output  word  to ALU operand 2
- alu_op_o  output  aluop  to ALU operation
- alu_result_i  input  word  from ALU result
- alu_busy_i  input  1  from ALU busy/stall
- busy_o  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- On reset:
  - State = IDLE; rr_ptr = 0.
  - Operand, op, owner and result registers = 0; op register = alu_nop.
  - All req_ready_o and rsp_valid_o = 0; busy_o = 0.
- States: IDLE, EXEC, RESP.
- Grant window is open in IDLE, or in RESP in the cycle the owner's rsp_valid_o & rsp_ready_i handshake completes.
- Arbitration (combinational): among asserted req_valid_i, pick the first index at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready_o[g] = 1 only for the winner, only while the grant window is open.
  - Ready depends on valid; requesters must not make valid depend on ready.
- Accept (valid & ready at edge T):
  - Capture data1/data2/op and owner = g.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - State <= EXEC.
  - rr_ptr changes only on an accept.
- EXEC:
  - alu_data1_o/alu_data2_o/alu_op_o are driven from the operand registers.
  - If alu_busy_i = 0: result_reg <= alu_result_i and state <= RESP.
  - If alu_busy_i = 1: hold EXEC with operands stable; no cycle limit.
- Outside EXEC: the ALU inputs are driven with 0/0/alu_nop so the ALU is quiescent.
- RESP:
  - rsp_valid_o[owner] = 1 and rsp_result_o = result_reg.
  - Both hold stable until rsp_ready_i[owner] = 1.
  - On handshake with a new grant in the same cycle: go to EXEC (back-to-back).
  - On handshake with no request pending: go to IDLE.
- Latency: accept at edge T, then rsp_valid_o high from cycle T+2 with no ALU stall.
- Throughput: one op per 2 cycles with rsp_ready_i held high.
- rsp_ready_i from non-owners is ignored.
- rsp_result_o is 0 when no rsp_valid_o is asserted.
- Result width: the full 32-bit word, passed unmodified. Compare ops return 0 or 1 in bit 0.
- Simultaneous events:
  - All requesters valid: service order follows rr_ptr strictly; no requester waits more than NUM_REQ-1 grants.
  - Withdrawing req_valid_i before the accept is permitted; no state change results.
- Reset mid-operation: the in-flight op is discarded. No response is ever produced for it, and requesters must re-issue.
- Assertions the verifier checks:
  - req_ready_o is onehot0; rsp_valid_o is onehot0.
  - rsp payload is stable while valid and not ready.
  - No grant occurs while in EXEC.

Test Plan:
- Single add: req0 (data1=5, data2=7, alu_add) in IDLE -> req_ready_o=01 at T; alu_op_o=alu_add in T+1; rsp_valid_o=01, rsp_result_o=12 at T+2; IDLE after handshake.
- Contention: req0 and req1 valid continuously, rsp_ready_i=11 -> grants alternate 0,1,0,1. Ops alu_sub 10-3 and alu_eq 4==4 return 7 and 1 on the correct owners, a new accept every 2 cycles.
- Backpressure: rsp_ready_i[1]=0 for 5 cycles after the result (alu_ge_s, -1>=0) -> rsp_valid_o=10 and rsp_result_o=0 stable; req0 valid meanwhile gets no ready; req0 is granted in the handshake cycle.
- ALU stall: alu_busy_i=1 for 3 cycles in EXEC -> operands held, busy_o=1, rsp_valid_o rises 1 cycle after busy drops, carrying the correct result (alu_ge_u 0xFFFFFFFF>=1 -> 1).
- Reset mid-op: rst_n low during EXEC -> all outputs go to reset values immediately (asynchronously); no rsp_valid_o after release; the next request is granted to req0 (rr_ptr=0).
- Idle quiescence: no requests for 20 cycles -> alu_op_o=alu_nop, alu_data1_o/alu_data2_o=0, busy_o=0, req_ready_o=0 throughout.
